// File: rtl/sprite_draw_unit_pkg.sv
// Shared helpers for the sprite draw unit: bit-width calculation and ARGB alpha field bounds.
// Alpha occupies the top quarter of the pixel word.
package sprite_draw_unit_pkg;

  function automatic int bit_width(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

  function automatic int alpha_msb(input int depth);
    return depth - 1;
  endfunction

  function automatic int alpha_lsb(input int depth);
    return depth - depth / 4;
  endfunction

endpackage

// File: rtl/sprite_bram.sv
// Simple dual-port sprite texture RAM: one write port, one registered read port, read-first.
// The read register is reset so the pixel output is 0 out of reset; the array itself is not.
module sprite_bram
  import sprite_draw_unit_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  (* ram_style = "block" *) logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sprite_draw_unit.sv
// Animated sprite pixel source: streams one pixel per draw beat with 2-cycle latency,
// with frame-end driven animation, horizontal flip and an alpha-keyed transparency flag.
module sprite_draw_unit
  import sprite_draw_unit_pkg::*;
#(
  parameter int  COLOR_DEPTH    = 16,
  parameter int  SPRITE_W       = 32,
  parameter int  SPRITE_H       = 32,
  parameter int  FRAME_NUM      = 4,
  parameter int  ANIM_CNT_WIDTH = 7,
  localparam int FRAME_W        = bit_width(FRAME_NUM)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [COLOR_DEPTH-1:0]    pixel_wd,
  input  logic                      pixel_we,
  input  logic                      wr_rst,
  input  logic                      fe,
  input  logic                      draw_vd,
  input  logic                      src_en,
  input  logic                      anim_en,
  input  logic [ANIM_CNT_WIDTH-1:0] anim_period,
  input  logic [FRAME_W-1:0]        frame_sel,
  input  logic                      flip_h,
  output logic [COLOR_DEPTH-1:0]    pixel,
  output logic                      pixel_vd,
  output logic                      transparent,
  output logic [FRAME_W-1:0]        frame_idx,
  output logic                      anim_tick
);

  localparam int COL_W  = bit_width(SPRITE_W);
  localparam int ROW_W  = bit_width(SPRITE_H);
  localparam int POS_W  = COL_W + ROW_W;
  localparam int ADDR_W = FRAME_W + POS_W;
  localparam int A_MSB  = alpha_msb(COLOR_DEPTH);
  localparam int A_LSB  = alpha_lsb(COLOR_DEPTH);

  logic                      beat;
  logic [POS_W-1:0]          pos;
  logic [COL_W-1:0]          col;
  logic [ROW_W-1:0]          row;
  logic                      flip;
  logic [FRAME_W-1:0]        frame;
  logic [ANIM_CNT_WIDTH-1:0] fe_cnt;
  logic [ANIM_CNT_WIDTH-1:0] period_m1;
  logic                      anim_on;
  logic                      step;
  logic [ADDR_W-1:0]         rd_addr;
  logic [ADDR_W-1:0]         wptr;
  logic                      vld1;
  logic                      vld2;

  // A frame end in the same cycle as a beat restarts the sprite and drops the beat.
  assign beat      = draw_vd & src_en & ~fe;
  // Row and column share one counter; power-of-2 sizes make the row/sprite wrap free.
  assign col       = pos[COL_W-1:0];
  assign row       = pos[POS_W-1:COL_W];
  assign period_m1 = anim_period - ANIM_CNT_WIDTH'(1);
  assign anim_on   = anim_en & (anim_period != '0);
  assign step      = fe & anim_on & (fe_cnt == period_m1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos  <= '0;
      flip <= 1'b0;
    end else if (fe) begin
      pos  <= '0;
      flip <= flip_h;
    end else if (beat) begin
      pos  <= pos + POS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame     <= '0;
      fe_cnt    <= '0;
      anim_tick <= 1'b0;
    end else begin
      anim_tick <= step;
      if (fe) begin
        if (!anim_en) begin
          frame  <= frame_sel;
          fe_cnt <= '0;
        end else if (step) begin
          frame  <= frame + FRAME_W'(1);
          fe_cnt <= '0;
        end else if (anim_on) begin
          fe_cnt <= fe_cnt + ANIM_CNT_WIDTH'(1);
        end
      end
    end
  end

  // Mirrored column is W-1-col, which for a power-of-2 width is the bitwise inverse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr <= '0;
      vld1    <= 1'b0;
      vld2    <= 1'b0;
    end else begin
      vld1 <= beat;
      vld2 <= vld1;
      if (beat) rd_addr <= {frame, row, (flip ? ~col : col)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        wptr <= '0;
    else if (wr_rst)   wptr <= '0;
    else if (pixel_we) wptr <= wptr + ADDR_W'(1);
  end

  sprite_bram #(
    .DATA_W (COLOR_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_bram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (pixel_we & ~wr_rst),
    .wr_addr (wptr),
    .wr_data (pixel_wd),
    .rd_en   (vld1),
    .rd_addr (rd_addr),
    .rd_data (pixel)
  );

  assign pixel_vd    = vld2;
  assign transparent = vld2 & (pixel[A_MSB:A_LSB] == '0);
  assign frame_idx   = frame;

endmodule

// File: tb/tb_sprite_draw_unit.sv
// Directed bench for sprite_draw_unit: texture loaded through the write port, pixels
// collected at the falling edge and compared against hand-derived addresses.
module tb_sprite_draw_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pixel_wd;
  logic        pixel_we, wr_rst, fe, draw_vd, src_en, anim_en, flip_h;
  logic [6:0]  anim_period;
  logic [1:0]  frame_sel;
  logic [15:0] pixel;
  logic        pixel_vd, transparent, anim_tick;
  logic [1:0]  frame_idx;

  int checks = 0;
  int errors = 0;
  int ticks_seen;

  logic [15:0] pq[$];
  logic        tq[$];

  always #5 clk = ~clk;

  sprite_draw_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pixel_wd    (pixel_wd),
    .pixel_we    (pixel_we),
    .wr_rst      (wr_rst),
    .fe          (fe),
    .draw_vd     (draw_vd),
    .src_en      (src_en),
    .anim_en     (anim_en),
    .anim_period (anim_period),
    .frame_sel   (frame_sel),
    .flip_h      (flip_h),
    .pixel       (pixel),
    .pixel_vd    (pixel_vd),
    .transparent (transparent),
    .frame_idx   (frame_idx),
    .anim_tick   (anim_tick)
  );

  always @(negedge clk) begin
    if (pixel_vd) begin
      pq.push_back(pixel);
      tq.push_back(transparent);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_pix(input string tag, input int idx, input logic [15:0] exp);
    logic [31:0] got;
    got = (idx < pq.size()) ? {16'h0, pq[idx]} : 32'hDEAD_BEEF;
    chk($sformatf("%s[%0d]", tag, idx), got, {16'h0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fe_pulse();
    fe = 1'b1;
    tick();
    fe = 1'b0;
  endtask

  task automatic clear_q();
    pq.delete();
    tq.delete();
  endtask

  task automatic beats(input int n);
    clear_q();
    draw_vd = 1'b1;
    src_en  = 1'b1;
    repeat (n) tick();
    draw_vd = 1'b0;
    src_en  = 1'b0;
    repeat (3) tick();
  endtask

  task automatic write_word(input logic [15:0] d);
    pixel_we = 1'b1;
    pixel_wd = d;
    tick();
    pixel_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pixel_wd = '0; pixel_we = 1'b0; wr_rst = 1'b0; fe = 1'b0;
    draw_vd = 1'b0; src_en = 1'b0; anim_en = 1'b0; anim_period = '0;
    frame_sel = '0; flip_h = 1'b0;
    repeat (3) tick();
    chk("rst_pixel", {16'h0, pixel}, 32'h0);
    chk("rst_vd", {31'h0, pixel_vd}, 32'h0);
    chk("rst_transp", {31'h0, transparent}, 32'h0);
    chk("rst_frame", {30'h0, frame_idx}, 32'h0);
    chk("rst_tick", {31'h0, anim_tick}, 32'h0);
    #2 rst_n = 1'b1;
    tick();

    // Texture fill: word at address a is 0x1000 + a; pointer wraps back to 0.
    pixel_we = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      pixel_wd = 16'h1000 + 16'(i);
      tick();
    end
    pixel_we = 1'b0;
    chk("fill_no_vd", {31'h0, pixel_vd}, 32'h0);

    // Row 0, frame 0, no flip; first valid exactly two edges after the beat.
    clear_q();
    draw_vd = 1'b1; src_en = 1'b1;
    tick();
    chk("lat_t1_vd", {31'h0, pixel_vd}, 32'h0);
    tick();
    chk("lat_t2_vd", {31'h0, pixel_vd}, 32'h1);
    chk("lat_t2_pix", {16'h0, pixel}, 32'h1000);
    repeat (30) tick();
    draw_vd = 1'b0; src_en = 1'b0;
    repeat (3) tick();
    chk("row0_cnt", pq.size(), 32);
    for (int i = 0; i < 32; i++) chk_pix("row0", i, 16'h1000 + 16'(i));

    // Flip request without a frame end leaves row 1 unmirrored.
    flip_h = 1'b1;
    beats(32);
    for (int i = 0; i < 32; i += 7) chk_pix("noflip_row1", i, 16'h1020 + 16'(i));
    fe_pulse();
    beats(32);
    chk("flip_cnt", pq.size(), 32);
    for (int i = 0; i < 32; i++) chk_pix("flip_row0", i, 16'h101F - 16'(i));
    flip_h = 1'b0;
    fe_pulse();

    // Frame end coinciding with a beat mid-row: beat dropped, sprite restarts.
    clear_q();
    draw_vd = 1'b1; src_en = 1'b1;
    repeat (5) tick();
    fe = 1'b1;
    tick();
    fe = 1'b0;
    repeat (3) tick();
    draw_vd = 1'b0; src_en = 1'b0;
    repeat (3) tick();
    chk("fe_beat_cnt", pq.size(), 8);
    chk_pix("fe_beat", 4, 16'h1004);
    chk_pix("fe_beat", 5, 16'h1000);
    chk_pix("fe_beat", 6, 16'h1001);
    chk_pix("fe_beat", 7, 16'h1002);

    // Animation every 3rd frame end, wrapping 3 -> 0.
    anim_en = 1'b1; anim_period = 7'd3;
    ticks_seen = 0;
    for (int i = 1; i <= 12; i++) begin
      fe_pulse();
      if (anim_tick) ticks_seen++;
      chk($sformatf("anim_frame%0d", i), {30'h0, frame_idx}, 32'((i / 3) % 4));
      chk($sformatf("anim_tick%0d", i), {31'h0, anim_tick}, (i % 3 == 0) ? 32'h1 : 32'h0);
      tick();
      chk($sformatf("anim_tick_off%0d", i), {31'h0, anim_tick}, 32'h0);
    end
    chk("anim_ticks", ticks_seen, 4);
    repeat (3) fe_pulse();
    chk("anim_frame1", {30'h0, frame_idx}, 32'h1);
    beats(2);
    chk_pix("frame1", 0, 16'h1400);
    chk_pix("frame1", 1, 16'h1401);

    // Period 0 holds the current frame.
    anim_period = 7'd0;
    fe_pulse();
    chk("hold_tick", {31'h0, anim_tick}, 32'h0);
    fe_pulse();
    chk("hold_frame", {30'h0, frame_idx}, 32'h1);

    // Manual frame select, latched only at frame end.
    anim_en = 1'b0; frame_sel = 2'd3;
    fe_pulse();
    chk("man_frame3", {30'h0, frame_idx}, 32'h3);
    frame_sel = 2'd2;
    tick();
    chk("man_no_fe", {30'h0, frame_idx}, 32'h3);
    beats(1);
    chk_pix("frame3", 0, 16'h1C00);

    // Write port: pointer clear beats a simultaneous write.
    frame_sel = 2'd0;
    fe_pulse();
    wr_rst = 1'b1; tick(); wr_rst = 1'b0;
    for (int i = 1; i <= 5; i++) write_word(16'hA000 + 16'(i));
    wr_rst = 1'b1;
    write_word(16'hDEAD);
    wr_rst = 1'b0;
    write_word(16'hB000);
    beats(6);
    chk_pix("wr", 0, 16'hB000);
    chk_pix("wr", 1, 16'hA002);
    chk_pix("wr", 2, 16'hA003);
    chk_pix("wr", 4, 16'hA005);
    chk_pix("wr", 5, 16'h1005);

    // Alpha keying.
    write_word(16'h0FFF);
    write_word(16'h8FFF);
    fe_pulse();
    beats(3);
    chk_pix("alpha", 1, 16'h0FFF);
    chk("alpha_b000", (tq.size() > 0) ? {31'h0, tq[0]} : 32'hDEAD_BEEF, 32'h0);
    chk("alpha_0fff", (tq.size() > 1) ? {31'h0, tq[1]} : 32'hDEAD_BEEF, 32'h1);
    chk("alpha_8fff", (tq.size() > 2) ? {31'h0, tq[2]} : 32'hDEAD_BEEF, 32'h0);

    // Asynchronous reset mid-row with flip and frame 2 latched.
    flip_h = 1'b1; frame_sel = 2'd2;
    fe_pulse();
    chk("pre_rst_frame", {30'h0, frame_idx}, 32'h2);
    draw_vd = 1'b1; src_en = 1'b1;
    repeat (10) tick();
    #3 rst_n = 1'b0;
    #1;
    chk("arst_pixel", {16'h0, pixel}, 32'h0);
    chk("arst_vd", {31'h0, pixel_vd}, 32'h0);
    chk("arst_transp", {31'h0, transparent}, 32'h0);
    chk("arst_frame", {30'h0, frame_idx}, 32'h0);
    draw_vd = 1'b0; src_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    beats(2);
    chk("post_rst_cnt", pq.size(), 2);
    chk_pix("post_rst", 0, 16'hB000);
    chk_pix("post_rst", 1, 16'h0FFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
